// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller: forward-select encodings
// and memory-wait tracking states.
package pipe_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_M  = 2'b01,
        FWD_W  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        HZ_RUN  = 1'b0,
        HZ_WAIT = 1'b1
    } hz_state_t;

    localparam int REG_W = 5;

endpackage

// File: rtl/pipe_fwd_unit.sv
// Operand forward select for one E-stage source register.
// The younger result in M takes precedence over W; x0 is never forwarded.
module pipe_fwd_unit
    import pipe_pkg::*;
(
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rd_M,
    input  logic             reg_wr_M,
    input  logic [REG_W-1:0] rd_W,
    input  logic             reg_wr_W,
    output logic [1:0]       fwd_sel
);

    fwd_sel_t sel;

    always_comb begin
        sel = FWD_RF;
        if (reg_wr_M && (rd_M != '0) && (rd_M == rs)) begin
            sel = FWD_M;
        end else if (reg_wr_W && (rd_W != '0) && (rd_W == rs)) begin
            sel = FWD_W;
        end
    end

    assign fwd_sel = sel;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller: stall/flush generation with
// MEMWAIT > BRANCH > LOADUSE priority, dmem wait tracking and perf counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       rs1_D,
    input  logic [4:0]       rs2_D,
    input  logic             use_rs1_D,
    input  logic             use_rs2_D,
    input  logic [4:0]       rs1_E,
    input  logic [4:0]       rs2_E,
    input  logic [4:0]       rd_E,
    input  logic [4:0]       rd_M,
    input  logic [4:0]       rd_W,
    input  logic             reg_wr_E,
    input  logic             reg_wr_M,
    input  logic             reg_wr_W,
    input  logic             mem_rd_E,
    input  logic             br_taken_E,
    input  logic             dmem_req_M,
    input  logic             dmem_ready,
    output logic             stall_pc,
    output logic             stall_fetch,
    output logic             stall_decode,
    output logic             stall_execute,
    output logic             flush_fetch,
    output logic             flush_decode,
    output logic             flush_memory,
    output logic [1:0]       fwd_a_E,
    output logic [1:0]       fwd_b_E,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    hz_state_t         state;
    hz_state_t         state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_wait;
    logic              load_use;
    logic [1:0]        fwd_a_raw;
    logic [1:0]        fwd_b_raw;

    assign mem_wait = dmem_req_M && !dmem_ready;
    assign load_use = mem_rd_E && reg_wr_E && (rd_E != '0) &&
                      ((use_rs1_D && (rs1_D == rd_E)) ||
                       (use_rs2_D && (rs2_D == rd_E)));

    pipe_fwd_unit u_fwd_a (
        .rs       (rs1_E),
        .rd_M     (rd_M),
        .reg_wr_M (reg_wr_M),
        .rd_W     (rd_W),
        .reg_wr_W (reg_wr_W),
        .fwd_sel  (fwd_a_raw)
    );

    pipe_fwd_unit u_fwd_b (
        .rs       (rs2_E),
        .rd_M     (rd_M),
        .reg_wr_M (reg_wr_M),
        .rd_W     (rd_W),
        .reg_wr_W (reg_wr_W),
        .fwd_sel  (fwd_b_raw)
    );

    // A taken branch during a wait is held in E and only flushes once the wait ends.
    always_comb begin
        stall_pc      = 1'b0;
        stall_fetch   = 1'b0;
        stall_decode  = 1'b0;
        stall_execute = 1'b0;
        flush_fetch   = 1'b0;
        flush_decode  = 1'b0;
        flush_memory  = 1'b0;
        fwd_a_E       = FWD_RF;
        fwd_b_E       = FWD_RF;
        if (reset_n) begin
            fwd_a_E = fwd_a_raw;
            fwd_b_E = fwd_b_raw;
            if (mem_wait) begin
                stall_pc      = 1'b1;
                stall_fetch   = 1'b1;
                stall_decode  = 1'b1;
                stall_execute = 1'b1;
                flush_memory  = 1'b1;
            end else if (br_taken_E) begin
                flush_fetch  = 1'b1;
                flush_decode = 1'b1;
            end else if (load_use) begin
                stall_pc     = 1'b1;
                stall_fetch  = 1'b1;
                flush_decode = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            HZ_RUN:  if (mem_wait)  state_next = HZ_WAIT;
            HZ_WAIT: if (!mem_wait) state_next = HZ_RUN;
            default: state_next = HZ_RUN;
        endcase
    end

    // The timeout flag is sticky; the FSM keeps waiting rather than aborting the access.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= HZ_RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state <= state_next;
            if (mem_wait) begin
                if (wait_cnt != WAIT_W'(MAX_WAIT)) begin
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                end
                if (wait_cnt >= WAIT_W'(MAX_WAIT - 1)) begin
                    mem_timeout <= 1'b1;
                end
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (stall_pc && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (flush_fetch && (flush_events != '1)) begin
                flush_events <= flush_events + CNT_W'(1);
            end
        end
    end

endmodule
